// File: rtl/bcd_digit_source.sv
// BCD digit source: streams 0..9 (or 9..0) over a valid/ready handshake,
// counts completed sequences and stops after NUM_PASSES of them.
module bcd_digit_source #(
    parameter logic [3:0] TARGET     = 4'd9,
    parameter logic [7:0] NUM_PASSES = 8'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       out_ready,
    output logic [3:0] out_number,
    output logic       out_valid,
    output logic       target_hit,
    output logic       wrap,
    output logic [7:0] pass_count,
    output logic       busy,
    output logic       done,
    output logic       load_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_digit;
    logic       r_dir;
    logic       r_wrap;
    logic       r_loadErr;
    logic [7:0] r_passCount;

    logic [3:0] w_nextDigit;
    logic       w_isWrapDigit;
    logic [7:0] w_nextPass;
    logic       w_loadOk;

    // Next digit in the latched direction, wrap detection and saturating pass increment.
    always_comb begin
        w_nextDigit   = r_digit;
        w_isWrapDigit = 1'b0;
        w_nextPass    = r_passCount;
        w_loadOk      = (load_value <= 4'd9);
        if (r_dir) begin
            w_isWrapDigit = (r_digit == 4'd0);
            w_nextDigit   = (r_digit == 4'd0) ? 4'd9 : (r_digit - 4'd1);
        end else begin
            w_isWrapDigit = (r_digit == 4'd9);
            w_nextDigit   = (r_digit >= 4'd9) ? 4'd0 : (r_digit + 4'd1);
        end
        if (r_passCount != 8'd255) begin
            w_nextPass = r_passCount + 8'd1;
        end
    end

    // Control FSM with all state and outputs registered; stop beats load beats advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_digit     <= 4'd0;
            r_dir       <= 1'b0;
            r_wrap      <= 1'b0;
            r_loadErr   <= 1'b0;
            r_passCount <= 8'd0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state     <= RUN;
                        r_dir       <= dir;
                        r_passCount <= 8'd0;
                        r_loadErr   <= 1'b0;
                        r_digit     <= dir ? 4'd9 : 4'd0;
                    end else if (load && (r_state == IDLE)) begin
                        if (w_loadOk) begin
                            r_digit <= load_value;
                        end else begin
                            r_loadErr <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        r_state <= IDLE;
                    end else if (load) begin
                        if (w_loadOk) begin
                            r_digit <= load_value;
                        end else begin
                            r_loadErr <= 1'b1;
                        end
                    end else if (out_ready) begin
                        r_digit <= w_nextDigit;
                        if (w_isWrapDigit) begin
                            r_wrap      <= 1'b1;
                            r_passCount <= w_nextPass;
                            if (w_nextPass == NUM_PASSES) begin
                                r_state <= DONE;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_number = r_digit;
    assign out_valid  = (r_state == RUN);
    assign busy       = (r_state == RUN);
    assign done       = (r_state == DONE);
    assign wrap       = r_wrap;
    assign pass_count = r_passCount;
    assign load_err   = r_loadErr;
    assign target_hit = out_valid && (r_digit == TARGET);

endmodule

// File: tb/tb_bcd_digit_source.sv
// Directed bench for bcd_digit_source: two instances (one pass and two passes)
// share the same stimulus; each scenario checks the instance it targets.
module tb_bcd_digit_source;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       dir;
    logic       load;
    logic [3:0] load_value;
    logic       out_ready;

    logic [3:0] n1, n2;
    logic       v1, v2, th1, th2, w1, w2, b1, b2, d1, d2, le1, le2;
    logic [7:0] pc1, pc2;

    int vectorCount = 0;
    int missCount   = 0;

    bcd_digit_source #(.TARGET(4'd9), .NUM_PASSES(8'd1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
        .load(load), .load_value(load_value), .out_ready(out_ready),
        .out_number(n1), .out_valid(v1), .target_hit(th1), .wrap(w1),
        .pass_count(pc1), .busy(b1), .done(d1), .load_err(le1)
    );

    bcd_digit_source #(.TARGET(4'd9), .NUM_PASSES(8'd2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir),
        .load(load), .load_value(load_value), .out_ready(out_ready),
        .out_number(n2), .out_valid(v2), .target_hit(th2), .wrap(w2),
        .pass_count(pc2), .busy(b2), .done(d2), .load_err(le2)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the given number of rising edges, landing just after the last one.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Main directed sequence.
    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0;
        load = 1'b0; load_value = 4'd0; out_ready = 1'b0;
        applyStimulus(2);
        checkOutput("rst_number", n1, 0);
        checkOutput("rst_valid", v1, 0);
        checkOutput("rst_wrap", w1, 0);
        checkOutput("rst_pass", pc1, 0);
        checkOutput("rst_done", d1, 0);
        checkOutput("rst_loaderr", le1, 0);
        checkOutput("rst_busy", b1, 0);
        rst = 1'b0;
        applyStimulus(2);
        checkOutput("idle_hold_busy", b1, 0);
        checkOutput("idle_hold_valid", v1, 0);

        // Up run, one pass.
        $display("[TB] up run");
        dir = 1'b0; out_ready = 1'b1; start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checkOutput("up_digit", n1, i);
            checkOutput("up_valid", v1, 1);
            checkOutput("up_target", th1, (i == 9) ? 1 : 0);
            checkOutput("up_wrap_low", w1, 0);
            applyStimulus(1);
        end
        checkOutput("up_wrap", w1, 1);
        checkOutput("up_pass", pc1, 1);
        checkOutput("up_done", d1, 1);
        checkOutput("up_valid_end", v1, 0);
        checkOutput("up_target_end", th1, 0);
        out_ready = 1'b0; stop = 1'b1;
        applyStimulus(1);
        stop = 1'b0;
        checkOutput("stop_in_done", d1, 1);
        checkOutput("wrap_one_cycle", w1, 0);
        checkOutput("stop_run_idle", b2, 0);

        // Backpressure at digit 4, start ignored while running.
        $display("[TB] backpressure");
        start = 1'b1; dir = 1'b0; out_ready = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("restart_pass_clr", pc1, 0);
        checkOutput("restart_done_clr", d1, 0);
        applyStimulus(4);
        checkOutput("bp_at4", n1, 4);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("bp_hold", n1, 4);
            checkOutput("bp_valid", v1, 1);
            checkOutput("bp_target", th1, 0);
        end
        out_ready = 1'b1;
        applyStimulus(1);
        checkOutput("bp_release", n1, 5);
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("start_in_run", n1, 6);
        applyStimulus(3);
        checkOutput("bp_at9", n1, 9);
        checkOutput("bp_target9", th1, 1);
        out_ready = 1'b0;
        applyStimulus(1);
        checkOutput("bp_hold9", n1, 9);
        checkOutput("bp_target_hold", th1, 1);
        stop = 1'b1;
        applyStimulus(1);
        stop = 1'b0;
        checkOutput("stop_valid", v1, 0);
        checkOutput("stop_target", th1, 0);
        checkOutput("stop_no_wrap", w1, 0);
        checkOutput("stop_digit", n1, 9);

        // Down run, two passes, dir toggled mid-run.
        $display("[TB] down run");
        dir = 1'b1; out_ready = 1'b1; start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        for (int p = 1; p <= 2; p++) begin
            for (int d = 9; d >= 0; d--) begin
                checkOutput("dn_digit", n2, d);
                checkOutput("dn_pass", pc2, p - 1);
                checkOutput("dn_wrap", w2, (d == 9 && p > 1) ? 1 : 0);
                if (d == 5) dir = ~dir;
                applyStimulus(1);
            end
        end
        checkOutput("dn_wrap_end", w2, 1);
        checkOutput("dn_pass_end", pc2, 2);
        checkOutput("dn_done", d2, 1);
        checkOutput("dn_valid_end", v2, 0);

        // Load and priority.
        $display("[TB] load");
        dir = 1'b0; start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        applyStimulus(2);
        checkOutput("ld_at2", n2, 2);
        load = 1'b1; load_value = 4'd7;
        applyStimulus(1);
        load = 1'b0;
        checkOutput("ld_7", n2, 7);
        checkOutput("ld_no_wrap", w2, 0);
        applyStimulus(1);
        checkOutput("ld_then8", n2, 8);
        load = 1'b1; load_value = 4'd12;
        applyStimulus(1);
        load = 1'b0;
        checkOutput("ld_bad_digit", n2, 8);
        checkOutput("ld_err", le2, 1);
        applyStimulus(1);
        checkOutput("ld_err_sticky", le2, 1);
        checkOutput("ld_after_bad", n2, 9);
        stop = 1'b1; load = 1'b1; load_value = 4'd3;
        applyStimulus(1);
        stop = 1'b0;
        checkOutput("stopld_idle", b2, 0);
        checkOutput("stopld_digit", n2, 9);
        load_value = 4'd5;
        applyStimulus(1);
        load = 1'b0;
        checkOutput("ld_idle", n2, 5);
        checkOutput("ld_idle_valid", v2, 0);
        start = 1'b1; load = 1'b1; load_value = 4'd4;
        applyStimulus(1);
        start = 1'b0; load = 1'b0;
        checkOutput("start_wins", n2, 0);
        checkOutput("start_clr_err", le2, 0);

        // Reset in the middle of the second pass.
        $display("[TB] reset mid-run");
        applyStimulus(16);
        checkOutput("mid_digit", n2, 6);
        checkOutput("mid_pass", pc2, 1);
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        checkOutput("mrst_digit", n2, 0);
        checkOutput("mrst_valid", v2, 0);
        checkOutput("mrst_pass", pc2, 0);
        checkOutput("mrst_done", d2, 0);
        checkOutput("mrst_busy", b2, 0);
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("mrst_restart", n2, 0);
        checkOutput("mrst_restart_v", v2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/bcd_digit_source.md
BCD_DIGIT_SOURCE -- requirements
Module: bcd_digit_source

Interface
REQ-001 SHALL have parameter TARGET, default 4'd9: digit value that raises target_hit.
REQ-002 SHALL have parameter NUM_PASSES, default 8'd1: full 0..9 sequences to emit before DONE (range 1..255).
REQ-003 SHALL have ports, clock and reset first:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin sequence from IDLE or DONE.
- stop  input  1  abort to IDLE.
- dir  input  1  0 = count up, 1 = count down; sampled only on accepted start.
- load  input  1  overwrite current digit.
- load_value  input  4  digit for load.
- out_ready  input  1  consumer accepts out_number.
- out_number  output  4  current BCD digit (0..9).
- out_valid  output  1  out_number is offered.
- target_hit  output  1  out_valid && out_number == TARGET.
- wrap  output  1  one-cycle pulse on sequence wrap.
- pass_count  output  8  completed sequences since start.
- busy  output  1  state == RUN.
- done  output  1  state == DONE.
- load_err  output  1  sticky: load attempted with load_value > 9.

Function
REQ-004 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-005 In IDLE or DONE, start = 1 SHALL move to RUN next cycle, latch dir, clear pass_count and load_err, and set out_number to 0 (up) or 9 (down).
REQ-006 start while in RUN SHALL be ignored.
REQ-007 out_valid SHALL be 1 exactly when state == RUN (registered, no combinational path from inputs).
REQ-008 Transfer SHALL occur on a cycle with out_valid && out_ready; out_number SHALL hold stable while out_valid && !out_ready.
REQ-009 On transfer, out_number SHALL advance next cycle: up 0->1..8->9->0; down 9->8..1->0->9; no value outside 0..9 SHALL ever appear.
REQ-010 A transfer of 9 (up) or 0 (down) SHALL be a wrap: wrap = 1 for the next cycle only, pass_count incremented, saturating at 255.
REQ-011 When a wrap brings pass_count to NUM_PASSES, the FSM SHALL enter DONE in the same update; out_valid = 0 and done = 1 from the next cycle.
REQ-012 Priority within RUN SHALL be stop > load > transfer-advance.
REQ-013 stop in RUN SHALL give IDLE next cycle with out_valid = 0; a coincident handshake SHALL produce no advance, wrap, or pass_count change.
REQ-014 stop in IDLE or DONE SHALL have no effect.
REQ-015 load with load_value <= 9 in IDLE or RUN SHALL set out_number = load_value next cycle; in RUN any coincident transfer SHALL not advance, and no wrap SHALL occur.
REQ-016 load with load_value > 9 SHALL leave out_number unchanged and set load_err = 1 until rst or accepted start.
REQ-017 load in DONE SHALL be ignored.
REQ-018 start and load in the same IDLE/DONE cycle: start SHALL win and load SHALL be ignored.
REQ-019 target_hit SHALL be combinational from registered out_valid and out_number only.

Reset
REQ-020 rst = 1 at a clock edge SHALL force IDLE, out_number = 0, out_valid = 0, wrap = 0, pass_count = 0, done = 0, load_err = 0, latched dir = 0, overriding all other inputs including mid-sequence.
REQ-021 After rst releases, the block SHALL stay in IDLE until start.

Verification
REQ-022 Up run: NUM_PASSES = 1, dir = 0, start, out_ready = 1 -> digits 0..9 on consecutive cycles, wrap one cycle after the 9 transfer, pass_count = 1, done = 1, out_valid = 0.
REQ-023 Backpressure: out_ready held 0 for 3 cycles at digit 4 -> out_number stays 4 with out_valid = 1, then 5 follows the accepting cycle; target_hit = 1 only while 9 is offered.
REQ-024 Down run: NUM_PASSES = 2, dir = 1 -> 9..0, 9..0, with pass_count stepping 1 then 2, then DONE; toggling dir mid-run has no effect.
REQ-025 Load and priority: load = 1 with load_value = 7 at digit 2 with out_ready = 1 -> next digit 7 then 8; load_value = 12 -> digit unchanged and load_err = 1; stop plus load together -> IDLE.
REQ-026 Reset mid-run: rst asserted at digit 6 with pass_count = 1 -> next cycle all outputs at reset values; a following start restarts at 0.
